alu_share_arbiter: RTL and testbench

//  Shares one ArithmeticLogicUnit instance between NUM_REQ requesters (e.g. main pipe, branch/addr unit).

---
 rtl/alu_share_arbiter.sv | 153 +++++++++++++++
 tb/tb_alu_share_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Shares one external ALU between NUM_REQ requesters: arbitrate, execute one op, return the registered result.
// Define ALU_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority; default build is round-robin.
module alu_share_arbiter #(
  parameter int         NUM_REQ = 2,
  parameter logic [5:0] IDLE_OP = 6'b100001
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       reqValid,
  output logic [NUM_REQ-1:0]       reqReady,
  input  logic [NUM_REQ-1:0][5:0]  reqOp,
  input  logic [NUM_REQ-1:0][31:0] reqA,
  input  logic [NUM_REQ-1:0][31:0] reqB,
  output logic [NUM_REQ-1:0]       rspValid,
  input  logic [NUM_REQ-1:0]       rspReady,
  output logic [31:0]              rspResult,
  output logic                     rspOver,
  output logic                     rspZero,
  output logic [31:0]              aluInput1,
  output logic [31:0]              aluInput2,
  output logic [5:0]               aluOp,
  input  logic [31:0]              aluResult,
  input  logic                     aluOver,
  input  logic                     aluZero,
  output logic                     busy
);

  localparam int                  IDXW      = $clog2(NUM_REQ);
  localparam logic [IDXW:0]       NUM_REQ_W = (IDXW+1)'(NUM_REQ);
  localparam logic [IDXW-1:0]     LAST_RST  = IDXW'(NUM_REQ-1);
  localparam logic [NUM_REQ-1:0]  ONE_HOT0  = NUM_REQ'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [IDXW-1:0]   last_grant_q, last_grant_d;
  logic [IDXW-1:0]   owner_q, owner_d;
  logic [5:0]        op_q, op_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic [31:0]       result_q, result_d;
  logic              over_q, over_d;
  logic              zero_q, zero_d;

  logic [IDXW-1:0]   grant_s;
  logic              grant_vld_s;
  logic [IDXW:0]     base_s;
  logic [IDXW:0]     sum_s;
  logic [2*NUM_REQ-1:0] dbl_s;

  // Grant selection; the loop runs high-to-low so the first eligible candidate is assigned last and wins.
  always_comb begin
    grant_vld_s = |reqValid;
    grant_s     = '0;
    base_s      = '0;
    sum_s       = '0;
    dbl_s       = '0;
`ifdef ALU_ARB_FIXED_PRIO_EN
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      grant_s = reqValid[k] ? IDXW'(k) : grant_s;
    end
`else
    base_s = {1'b0, last_grant_q} + (IDXW+1)'(1);
    base_s = (base_s >= NUM_REQ_W) ? (IDXW+1)'(0) : base_s;
    dbl_s  = {reqValid, reqValid} >> base_s;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      sum_s   = base_s + (IDXW+1)'(k);
      sum_s   = (sum_s >= NUM_REQ_W) ? (sum_s - NUM_REQ_W) : sum_s;
      grant_s = dbl_s[k] ? sum_s[IDXW-1:0] : grant_s;
    end
`endif
  end

  // Next-state and datapath capture for the IDLE -> EXEC -> RESP sequence.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    result_d     = result_q;
    over_d       = over_q;
    zero_d       = zero_q;
    case (state_q)
      IDLE: begin
        if (grant_vld_s) begin
          state_d = EXEC;
          owner_d = grant_s;
          op_d    = reqOp[grant_s];
          a_d     = reqA[grant_s];
          b_d     = reqB[grant_s];
`ifndef ALU_ARB_FIXED_PRIO_EN
          last_grant_d = grant_s;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        state_d  = RESP;
        result_d = aluResult;
        over_d   = aluOver;
        zero_d   = aluZero;
      end
      RESP: begin
        if (rspReady[owner_q]) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any op in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= LAST_RST;
      owner_q      <= '0;
      op_q         <= 6'd0;
      a_q          <= 32'd0;
      b_q          <= 32'd0;
      result_q     <= 32'd0;
      over_q       <= 1'b0;
      zero_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      result_q     <= result_d;
      over_q       <= over_d;
      zero_q       <= zero_d;
    end
  end

  // reqReady is gated by rst_n so it reads zero while reset is held, even with requests pending.
  assign reqReady  = (rst_n && (state_q == IDLE) && grant_vld_s) ? (ONE_HOT0 << grant_s) : '0;
  assign rspValid  = (state_q == RESP) ? (ONE_HOT0 << owner_q) : '0;
  assign rspResult = result_q;
  assign rspOver   = over_q;
  assign rspZero   = zero_q;
  assign aluInput1 = (state_q == EXEC) ? a_q : 32'd0;
  assign aluInput2 = (state_q == EXEC) ? b_q : 32'd0;
  assign aluOp     = (state_q == EXEC) ? op_q : IDLE_OP;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomised bench for alu_share_arbiter with a behavioural ALU and a transaction-level arbitration model.
module tb_alu_share_arbiter;

  localparam int         N       = 2;
  localparam logic [5:0] OP_ADD  = 6'h20, OP_ADDU = 6'h21, OP_SUB = 6'h22, OP_SUBU = 6'h23;
  localparam logic [5:0] OP_AND  = 6'h24, OP_OR   = 6'h25, OP_XOR = 6'h26, OP_NOR  = 6'h27;
  localparam logic [5:0] OP_SLT  = 6'h2A, OP_SLTU = 6'h2B, OP_SLL = 6'h00, OP_SRL  = 6'h02;
  localparam logic [5:0] OP_SRA  = 6'h03;
  localparam logic [5:0] IDLE_OP = OP_ADDU;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [N-1:0]        reqValid, reqReady, rspValid, rspReady;
  logic [N-1:0][5:0]   reqOp;
  logic [N-1:0][31:0]  reqA, reqB;
  logic [31:0]         rspResult, aluInput1, aluInput2, aluResult;
  logic                rspOver, rspZero, aluOver, aluZero, busy;
  logic [5:0]          aluOp;

  int n_checks = 0;
  int n_errors = 0;
  int model_last;
  logic [5:0] op_tbl [13] = '{OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_AND, OP_OR, OP_XOR,
                              OP_NOR, OP_SLT, OP_SLTU, OP_SLL, OP_SRL, OP_SRA};

  alu_share_arbiter #(.NUM_REQ(N), .IDLE_OP(IDLE_OP)) dut (
    .clk(clk), .rst_n(rst_n), .reqValid(reqValid), .reqReady(reqReady), .reqOp(reqOp),
    .reqA(reqA), .reqB(reqB), .rspValid(rspValid), .rspReady(rspReady), .rspResult(rspResult),
    .rspOver(rspOver), .rspZero(rspZero), .aluInput1(aluInput1), .aluInput2(aluInput2),
    .aluOp(aluOp), .aluResult(aluResult), .aluOver(aluOver), .aluZero(aluZero), .busy(busy)
  );

  always #5 clk = ~clk;

  // Returns {over, zero, result}.
  function automatic logic [33:0] alu_model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        ov;
    ov = 1'b0;
    case (op)
      OP_ADD:  begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
      OP_ADDU: r = a + b;
      OP_SUB:  begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
      OP_SUBU: r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      OP_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU: r = (a < b) ? 32'd1 : 32'd0;
      OP_SLL:  r = b << a[4:0];
      OP_SRL:  r = b >> a[4:0];
      OP_SRA:  r = $signed(b) >>> a[4:0];
      default: r = 32'd0;
    endcase
    return {ov, (r == 32'd0), r};
  endfunction

  always_comb {aluOver, aluZero, aluResult} = alu_model(aluOp, aluInput1, aluInput2);

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int model_pick(input logic [N-1:0] v);
`ifdef ALU_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (v[i]) return i;
`else
    for (int k = 1; k <= N; k++) if (v[(model_last + k) % N]) return (model_last + k) % N;
`endif
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    reqOp[i] = op; reqA[i] = a; reqB[i] = b;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_busy"}, 64'(busy), 64'(0));
    check_eq({tag, "_rspValid"}, 64'(rspValid), 64'(0));
    check_eq({tag, "_aluOp"}, 64'(aluOp), 64'(IDLE_OP));
    check_eq({tag, "_aluIn"}, {aluInput1, aluInput2}, 64'(0));
  endtask

  // One full transaction from request to response consumption; returns the granted index (-1 if none).
  task automatic run_op(input logic [N-1:0] vmask, input int hold, output int w);
    logic [33:0] exp;
    logic [5:0]  eop;
    logic [31:0] ea, eb;
    logic [N-1:0] own;
    reqValid = vmask; rspReady = '0; #1;
    w = model_pick(vmask);
    if (w < 0) begin
      check_eq("reqReady_none", 64'(reqReady), 64'(0));
      @(posedge clk); #1;
      check_idle("noop");
      return;
    end
    own = '0; own[w] = 1'b1;
    check_eq("reqReady", 64'(reqReady), 64'(own));
    eop = reqOp[w]; ea = reqA[w]; eb = reqB[w];
    exp = alu_model(eop, ea, eb);
`ifndef ALU_ARB_FIXED_PRIO_EN
    model_last = w;
`endif
    @(posedge clk); #1;
    reqValid = N'($urandom);
    for (int i = 0; i < N; i++) set_req(i, 6'($urandom), $urandom, $urandom);
    #1;
    check_eq("exec_busy", 64'(busy), 64'(1));
    check_eq("exec_reqReady", 64'(reqReady), 64'(0));
    check_eq("exec_rspValid", 64'(rspValid), 64'(0));
    check_eq("exec_aluOp", 64'(aluOp), 64'(eop));
    check_eq("exec_aluIn", {aluInput1, aluInput2}, {ea, eb});
    @(posedge clk); #1;
    for (int h = 0; h <= hold; h++) begin
      check_eq("rsp_valid", 64'(rspValid), 64'(own));
      check_eq("rsp_result", 64'(rspResult), 64'(exp[31:0]));
      check_eq("rsp_flags", 64'({rspOver, rspZero}), 64'(exp[33:32]));
      check_eq("rsp_reqReady", 64'(reqReady), 64'(0));
      check_eq("rsp_aluOp", 64'(aluOp), 64'(IDLE_OP));
      rspReady = (N'($urandom) & ~own) | ((h == hold) ? own : '0);
      reqValid = N'($urandom);
      @(posedge clk); #1;
    end
    reqValid = '0; rspReady = '0; #1;
    check_idle("post");
  endtask

  task automatic do_reset();
    reqValid = '0; rspReady = '0; rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    model_last = N - 1;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int exp_seq [4];
    rst_n = 1'b0; reqValid = 2'b11; rspReady = '0;
    for (int i = 0; i < N; i++) set_req(i, OP_ADD, 32'd1, 32'd1);
    repeat (2) @(posedge clk); #1;
    check_eq("rst_reqReady", 64'(reqReady), 64'(0));
    check_eq("rst_rsp", {rspResult, 30'd0, rspOver, rspZero}, 64'(0));
    check_idle("rst");
    do_reset();

    // Directed: ADD 5+7 from requester 0.
    set_req(0, OP_ADD, 32'd5, 32'd7);
    run_op(2'b01, 0, w);
    check_eq("t1_grant", 64'(w), 64'(0));

    // Directed: both requesting, four ops back to back.
    do_reset();
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_seq = '{0, 0, 0, 0};
`else
    exp_seq = '{0, 1, 0, 1};
`endif
    for (int n = 0; n < 4; n++) begin
      set_req(0, OP_ADDU, 32'(n), 32'd100);
      set_req(1, OP_XOR, 32'(n), 32'hFFFF0000);
      run_op(2'b11, 0, w);
      check_eq("t2_grant", 64'(w), 64'(exp_seq[n]));
    end

    // Directed: signed overflow on SUB from requester 1 with a long response stall.
    set_req(1, OP_SUB, 32'h80000000, 32'd1);
    run_op(2'b10, 5, w);

    // Directed: zero flag and signed/unsigned compare.
    set_req(0, OP_SUB, 32'd9, 32'd9);          run_op(2'b01, 1, w);
    set_req(0, OP_SLT, 32'hFFFFFFFF, 32'd1);   run_op(2'b01, 0, w);
    set_req(0, OP_SLTU, 32'hFFFFFFFF, 32'd1);  run_op(2'b01, 0, w);

    // Directed: reset asserted while an op is executing.
    set_req(1, OP_ADD, 32'd1, 32'd2);
    reqValid = 2'b10; #1;
    @(posedge clk); #1;
    reqValid = '0;
    check_eq("t5_in_exec", 64'(busy), 64'(1));
    #1 rst_n = 1'b0; #1;
    check_eq("t5_rst_rspValid", 64'(rspValid), 64'(0));
    check_eq("t5_rst_busy", 64'(busy), 64'(0));
    @(negedge clk); rst_n = 1'b1; model_last = N - 1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check_idle("t5_after");
    end
    set_req(0, OP_OR, 32'h0F, 32'hF0);
    set_req(1, OP_AND, 32'h0F, 32'hFF);
    run_op(2'b11, 0, w);
    check_eq("t5_grant", 64'(w), 64'(0));

    // Random traffic.
    for (int it = 0; it < 80; it++) begin
      for (int i = 0; i < N; i++) begin
        logic [31:0] a, b;
        a = ($urandom_range(0, 3) == 0) ? 32'h7FFFFFFF : $urandom;
        b = ($urandom_range(0, 3) == 0) ? a : $urandom;
        set_req(i, op_tbl[$urandom_range(0, 12)], a, b);
      end
      run_op(N'($urandom_range(0, 3)), $urandom_range(0, 3), w);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
